sram_req_ctrl: RTL

//  Request sequencer directly upstream of the single-port SRAM.

---
 rtl/sram_req_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: in-order request sequencer in front of a single-port SRAM.
// Requests are queued in a small FIFO and issued one at a time on registered
// SRAM pins. Reads are completed on a valid/ready response port, which hides
// the one-cycle SRAM read latency from the master.
//
// Handshakes (both ports): a transfer happens on the rising clock edge where
// valid && ready are both high. valid, once raised, holds its payload stable
// until that edge. ready may change freely. req_ready is derived from the
// registered FIFO count only, so it never depends combinationally on req_valid.
module sram_req_ctrl #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_wen,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic                          sram_wen,
  output logic [DATA_W-1:0]             sram_wdata,
  input  logic [DATA_W-1:0]             sram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD      = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RSP     = 3'd4
  } state_t;

  // FIFO storage: entry = {wen, addr, wdata}
  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  state_t            r_state;
  logic [ADDR_W-1:0] r_sram_addr;
  logic              r_sram_wen;
  logic [DATA_W-1:0] r_sram_wdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [ENT_W-1:0]  w_head;
  logic              w_head_wen;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_wdata;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_sram_addr_nxt;
  logic              w_sram_wen_nxt;
  logic [DATA_W-1:0] w_sram_wdata_nxt;
  logic              w_rsp_valid_nxt;
  logic [DATA_W-1:0] w_rsp_rdata_nxt;

  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_push       = req_valid && !w_full;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_wen   = w_head[ENT_W-1];
  assign w_head_addr  = w_head[ADDR_W+DATA_W-1:DATA_W];
  assign w_head_wdata = w_head[DATA_W-1:0];

  assign req_ready  = !w_full;
  assign fifo_count = r_count;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign sram_addr  = r_sram_addr;
  assign sram_wen   = r_sram_wen;
  assign sram_wdata = r_sram_wdata;
  assign dbg_state  = r_state;

  // FIFO payload write; storage needs no reset since count guards it
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {req_wen, req_addr, req_wdata};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Next-state, pop decision and next values of the registered pins
  always_comb begin
    w_state_nxt      = r_state;
    w_pop            = 1'b0;
    w_sram_addr_nxt  = r_sram_addr;
    w_sram_wen_nxt   = 1'b0;
    w_sram_wdata_nxt = r_sram_wdata;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_rdata_nxt  = r_rsp_rdata;
    case (r_state)
      S_IDLE, S_WR: begin
        if (!w_empty) begin
          w_pop            = 1'b1;
          w_sram_addr_nxt  = w_head_addr;
          w_sram_wen_nxt   = w_head_wen;
          w_sram_wdata_nxt = w_head_wdata;
          w_state_nxt      = w_head_wen ? S_WR : S_RD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        // SRAM samples the address at this edge; data arrives next cycle
        w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_rsp_rdata_nxt = sram_rdata;
        w_rsp_valid_nxt = 1'b1;
        w_state_nxt     = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus registered SRAM pins and response port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sram_addr  <= '0;
      r_sram_wen   <= 1'b0;
      r_sram_wdata <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_sram_addr  <= w_sram_addr_nxt;
      r_sram_wen   <= w_sram_wen_nxt;
      r_sram_wdata <= w_sram_wdata_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_rdata  <= w_rsp_rdata_nxt;
    end
  end

endmodule
